// File: rtl/local_history_table.sv
// Per-index local branch history table with a global history register.
// Entries are wiped by an ascending sweep after reset or flush, and lookups are blanked until that sweep finishes.
module local_history_table #(
  parameter int HIST_W = 5,
  parameter int IDX_W  = 5,
  parameter int GHR_W  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [IDX_W-1:0]  rd_index,
  output logic [HIST_W-1:0] rd_hist,
  input  logic              upd_valid,
  input  logic [IDX_W-1:0]  upd_index,
  input  logic              upd_taken,
  input  logic              flush,
  output logic              ready,
  output logic [GHR_W-1:0]  ghr,
  output logic [15:0]       upd_count
);

  // state  | meaning
  // -------+-------------------------------------------------------------
  // CLEAR  | sweeping entries to zero, one per cycle; ready low
  // IDLE   | table valid; accepts updates; flush returns to CLEAR
  typedef enum logic {
    S_CLEAR = 1'b0,
    S_IDLE  = 1'b1
  } state_t;

  localparam int DEPTH = 1 << IDX_W;

  state_t             state;
  logic [IDX_W-1:0]   sweep_ptr;
  logic [HIST_W-1:0]  mem [DEPTH];

  logic               accept;
  logic               wr_en;
  logic [IDX_W-1:0]   wr_addr;
  logic [HIST_W-1:0]  wr_data;

  // Reset and flush both win over an update arriving on the same edge.
  assign accept = !reset && (state == S_IDLE) && upd_valid && !flush;

  always_comb begin
    wr_en   = 1'b0;
    wr_addr = upd_index;
    wr_data = {mem[upd_index][HIST_W-2:0], upd_taken};
    if (!reset) begin
      if (state == S_CLEAR && !flush) begin
        wr_en   = 1'b1;
        wr_addr = sweep_ptr;
        wr_data = '0;
      end else if (accept) begin
        wr_en = 1'b1;
      end
    end
  end

  // Array has no reset; the sweep is what establishes its contents.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_CLEAR;
      sweep_ptr <= '0;
      ghr       <= '0;
      upd_count <= '0;
    end else begin
      case (state)
        S_CLEAR: begin
          if (flush) begin
            sweep_ptr <= '0;
          end else begin
            sweep_ptr <= sweep_ptr + 1'b1;
            if (sweep_ptr == {IDX_W{1'b1}}) begin
              state <= S_IDLE;
            end
          end
        end
        S_IDLE: begin
          if (flush) begin
            state     <= S_CLEAR;
            sweep_ptr <= '0;
            ghr       <= '0;
            upd_count <= '0;
          end else if (upd_valid) begin
            ghr <= {ghr[GHR_W-2:0], upd_taken};
            if (upd_count != 16'hFFFF) begin
              upd_count <= upd_count + 16'd1;
            end
          end
        end
        default: begin
          state     <= S_CLEAR;
          sweep_ptr <= '0;
        end
      endcase
    end
  end

  assign ready   = (state == S_IDLE);
  assign rd_hist = ready ? mem[rd_index] : '0;

endmodule

// File: tb/tb_local_history_table.sv
// Directed and randomized checks of local_history_table against a behavioural table model.
module tb_local_history_table;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] rd_index;
  logic [4:0] rd_hist;
  logic       upd_valid;
  logic [4:0] upd_index;
  logic       upd_taken;
  logic       flush;
  logic       ready;
  logic [7:0] ghr;
  logic [15:0] upd_count;

  local_history_table dut (
    .clk(clk), .reset(reset), .rd_index(rd_index), .rd_hist(rd_hist),
    .upd_valid(upd_valid), .upd_index(upd_index), .upd_taken(upd_taken),
    .flush(flush), .ready(ready), .ghr(ghr), .upd_count(upd_count)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Model: table contents, history, count, and cycles left until the table is usable.
  logic [4:0]  m_mem [32];
  logic [7:0]  m_ghr;
  logic [15:0] m_cnt;
  int          clear_left;

  task automatic model_clear();
    for (int i = 0; i < 32; i++) m_mem[i] = '0;
    clear_left = 32;
  endtask

  task automatic model_edge();
    if (reset) begin
      model_clear();
      m_ghr = 0;
      m_cnt = 0;
    end else if (clear_left > 0) begin
      if (flush) clear_left = 32;
      else clear_left = clear_left - 1;
    end else if (flush) begin
      model_clear();
      m_ghr = 0;
      m_cnt = 0;
    end else if (upd_valid) begin
      m_mem[upd_index] = {m_mem[upd_index][3:0], upd_taken};
      m_ghr = {m_ghr[6:0], upd_taken};
      if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
    end
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_model();
    logic [4:0] e_hist;
    e_hist = (clear_left == 0) ? m_mem[rd_index] : 5'd0;
    check("ready", 16'(ready), 16'(clear_left == 0));
    check("rd_hist", 16'(rd_hist), 16'(e_hist));
    check("ghr", 16'(ghr), 16'(m_ghr));
    check("upd_count", upd_count, m_cnt);
  endtask

  // One clock: drive inputs at negedge, check combinational/registered outputs, then clock.
  task automatic cyc(input logic r, input logic f, input logic v, input logic [4:0] ui,
                     input logic t, input logic [4:0] ri, input bit chk);
    reset = r; flush = f; upd_valid = v; upd_index = ui; upd_taken = t; rd_index = ri;
    #1;
    if (chk) check_model();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 5'(i), 1);
  endtask

  task automatic peek(input string tag, input logic [4:0] idx, input logic [4:0] exp);
    reset = 0; flush = 0; upd_valid = 0; rd_index = idx;
    #1;
    check(tag, 16'(rd_hist), 16'(exp));
  endtask

  initial begin
    reset = 0; flush = 0; upd_valid = 0; upd_index = 0; upd_taken = 0; rd_index = 0;
    for (int i = 0; i < 32; i++) m_mem[i] = '0;
    m_ghr = 0; m_cnt = 0; clear_left = 32;
    @(negedge clk);
    // Power-up: outputs are undefined until the first reset edge.
    reset = 1; @(posedge clk); model_edge(); @(negedge clk);

    // Reset then 32 cycles of ready low, then every index reads zero.
    cyc(1, 0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 32; i++) begin
      reset = 0; #1; check("sweep_ready_low", 16'(ready), 16'd0);
      check("sweep_hist_zero", 16'(rd_hist), 16'd0);
      @(posedge clk); model_edge(); @(negedge clk);
    end
    check("ready_after_32", 16'(ready), 16'd1);
    for (int i = 0; i < 32; i++) peek("post_reset_zero", 5'(i), 5'd0);
    check("ghr_reset", 16'(ghr), 16'd0);
    check("cnt_reset", upd_count, 16'd0);

    // Index 3: T,T,N,T.
    cyc(0, 0, 1, 3, 1, 3, 1);
    cyc(0, 0, 1, 3, 1, 3, 1);
    cyc(0, 0, 1, 3, 0, 3, 1);
    cyc(0, 0, 1, 3, 1, 3, 1);
    peek("idx3_hist", 3, 5'b01101);
    check("idx3_ghr", 16'(ghr), 16'h0D);
    check("idx3_cnt", upd_count, 16'd4);
    peek("idx4_zero", 4, 5'd0);

    // Index 7: six taken, oldest bit falls off.
    for (int i = 0; i < 6; i++) cyc(0, 0, 1, 7, 1, 7, 1);
    peek("idx7_sat", 7, 5'b11111);
    peek("idx3_hold", 3, 5'b01101);

    // Read-during-write on index 2.
    cyc(0, 0, 1, 2, 1, 0, 1);
    peek("idx2_pre", 2, 5'b00001);
    cyc(0, 0, 1, 2, 1, 2, 1);
    peek("idx2_post", 2, 5'b00011);

    // Flush with a coincident update: update dropped, full sweep, updates ignored during it.
    cyc(0, 1, 1, 9, 1, 9, 1);
    check("flush_cnt", upd_count, 16'd0);
    check("flush_ghr", 16'(ghr), 16'd0);
    for (int i = 0; i < 32; i++) begin
      check("flush_ready_low", 16'(ready), 16'd0);
      cyc(0, 0, (i % 3) == 0, 5'(i), 1, 5'(i), 1);
    end
    check("flush_ready_high", 16'(ready), 16'd1);
    check("flush_cnt_sweep", upd_count, 16'd0);
    for (int i = 0; i < 32; i++) peek("flush_zero", 5'(i), 5'd0);

    // Flush at sweep pointer 20 restarts the sweep.
    cyc(0, 1, 0, 0, 0, 0, 1);
    idle(20);
    cyc(0, 1, 0, 0, 0, 0, 1);
    idle(31);
    check("restart_not_ready", 16'(ready), 16'd0);
    idle(1);
    check("restart_ready", 16'(ready), 16'd1);

    // Reset mid-sweep, with flush and update also asserted.
    cyc(0, 1, 0, 0, 0, 0, 1);
    idle(10);
    cyc(1, 1, 1, 4, 1, 4, 1);
    idle(32);
    check("midsweep_reset_ready", 16'(ready), 16'd1);

    // Saturation of the update counter.
    for (int i = 0; i < 70000; i++)
      cyc(0, 0, 1, 5'($urandom_range(0, 31)), 1'($urandom), 5'($urandom_range(0, 31)), (i % 4096) == 0);
    check("cnt_saturated", upd_count, 16'hFFFF);
    cyc(0, 0, 1, 1, 1, 1, 1);
    check("cnt_hold", upd_count, 16'hFFFF);

    // Randomized traffic with occasional flush and reset.
    for (int i = 0; i < 1500; i++)
      cyc(($urandom_range(0, 255) == 0), ($urandom_range(0, 99) == 0), 1'($urandom),
          5'($urandom_range(0, 31)), 1'($urandom), 5'($urandom_range(0, 31)), 1);
    idle(40);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
